// File: rtl/bo_byte_buffer.sv
// Byte-out output buffer: absorbs 0/1/2 coded bytes per cycle, emits one byte per cycle
// on a first-word fall-through valid/ready stream. Optional byte counter: BO_BYTE_CNT_EN.
module bo_byte_buffer #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [15:0]   in_data,
  input  logic [1:0]    in_cnt,
  input  logic          in_flush,
  output logic [7:0]    out_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_last,
  output logic [AW:0]   level,
  output logic          full,
  output logic          ovf,
  output logic [31:0]   byte_cnt
);

  localparam int unsigned LVW = AW + 1;
  localparam int unsigned NW  = AW + 2;

  logic [7:0]       mem_q [DEPTH];
  logic [DEPTH-1:0] tag_q, tag_d;
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW-1:0]    wr_ptr_p1, wr_ptr_m1;
  logic [AW:0]      level_q, level_d, level_pop;
  logic             ovf_q, ovf_d;
  logic             pop, accept, we0, we1;
  logic [NW-1:0]    need;
  logic [1:0]       acc_cnt;
  logic [7:0]       wdata0;

  assign out_valid = (level_q != '0);
  assign out_data  = out_valid ? mem_q[rd_ptr_q] : 8'h00;
  assign out_last  = out_valid & tag_q[rd_ptr_q];
  assign level     = level_q;
  assign full      = (level_q > LVW'(DEPTH - 2));
  assign ovf       = ovf_q;

  // Acceptance counts the same-cycle pop; a write is taken whole or not at all.
  assign pop       = out_valid & out_ready;
  assign level_pop = level_q - LVW'(pop);
  assign need      = NW'(level_pop) + NW'(in_cnt);
  assign accept    = (in_cnt != 2'd0) && (in_cnt != 2'd3) && (need <= NW'(DEPTH));
  assign acc_cnt   = accept ? in_cnt : 2'd0;
  assign we0       = accept;
  assign we1       = accept && (in_cnt == 2'd2);
  assign wdata0    = (in_cnt == 2'd2) ? in_data[15:8] : in_data[7:0];
  assign wr_ptr_p1 = wr_ptr_q + AW'(1);
  assign wr_ptr_m1 = wr_ptr_q - AW'(1);

  always_comb begin
    tag_d    = tag_q;
    wr_ptr_d = wr_ptr_q + AW'(acc_cnt);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    level_d  = level_pop + LVW'(acc_cnt);
    ovf_d    = ovf_q | ((in_cnt != 2'd0) && !accept);
    if (we0) tag_d[wr_ptr_q]  = in_flush & ~we1;
    if (we1) tag_d[wr_ptr_p1] = in_flush;
    // Flush with no accepted write marks the newest surviving entry.
    if (!accept && in_flush && (level_pop != '0)) tag_d[wr_ptr_m1] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      ovf_q    <= ovf_d;
    end
  end

  // Payload storage needs no reset: out_data is gated by out_valid.
  always_ff @(posedge clk) begin
    if (we0) mem_q[wr_ptr_q]  <= wdata0;
    if (we1) mem_q[wr_ptr_p1] <= in_data[7:0];
  end

`ifdef BO_BYTE_CNT_EN
  logic [31:0] cnt_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= 32'd0;
    else      cnt_q <= cnt_q + 32'(acc_cnt);
  end

  assign byte_cnt = cnt_q;
`else
  assign byte_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_bo_byte_buffer.sv
// Self-checking bench for bo_byte_buffer: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_bo_byte_buffer;

  logic        clk, rst;
  logic [15:0] in_data;
  logic [1:0]  in_cnt;
  logic        in_flush, out_ready;
  logic [7:0]  out_data;
  logic        out_valid, out_last, full, ovf;
  logic [4:0]  level;
  logic [31:0] byte_cnt;

  bo_byte_buffer #(.DEPTH(16), .AW(4)) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_cnt(in_cnt), .in_flush(in_flush),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_last(out_last),
    .level(level), .full(full), .ovf(ovf), .byte_cnt(byte_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: queue of {tag, byte}, sticky overflow, accepted-byte count.
  logic [8:0]  mq [$];
  logic        m_ovf;
  logic [31:0] m_cnt;
  logic [7:0]  rx [$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf = 1'b0;
    m_cnt = 32'd0;
  endtask

  task automatic check_outputs();
    logic [31:0] exp_cnt;
`ifdef BO_BYTE_CNT_EN
    exp_cnt = m_cnt;
`else
    exp_cnt = 32'd0;
`endif
    chk("out_valid", 32'(out_valid), 32'(mq.size() > 0));
    chk("out_data",  32'(out_data),  (mq.size() > 0) ? 32'(mq[0][7:0]) : 32'd0);
    chk("out_last",  32'(out_last),  (mq.size() > 0) ? 32'(mq[0][8]) : 32'd0);
    chk("level",     32'(level),     32'(mq.size()));
    chk("full",      32'(full),      32'(mq.size() > 14));
    chk("ovf",       32'(ovf),       32'(m_ovf));
    chk("byte_cnt",  byte_cnt,       exp_cnt);
  endtask

  task automatic model_step(input logic [15:0] d, input logic [1:0] c, input logic f, input logic r);
    int  after_pop;
    bit  acc;
    after_pop = mq.size() - ((r && mq.size() > 0) ? 1 : 0);
    acc = 1'b0;
    if (c == 2'd3) m_ovf = 1'b1;
    else if (c != 2'd0) begin
      if (after_pop + int'(c) <= 16) acc = 1'b1;
      else m_ovf = 1'b1;
    end
    if (r && mq.size() > 0) void'(mq.pop_front());
    if (acc) begin
      if (c == 2'd2) mq.push_back({1'b0, d[15:8]});
      mq.push_back({f, d[7:0]});
      m_cnt = m_cnt + 32'(c);
    end else if (f && mq.size() > 0) begin
      mq[mq.size()-1][8] = 1'b1;
    end
  endtask

  // One clock cycle: check at negedge, drive, advance model, cross the edge.
  task automatic cycle(input logic [15:0] d, input logic [1:0] c, input logic f, input logic r);
    check_outputs();
    in_data = d; in_cnt = c; in_flush = f; out_ready = r;
    if (out_valid && r) rx.push_back(out_data);
    model_step(d, c, f, r);
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    in_data = '0; in_cnt = '0; in_flush = 1'b0; out_ready = 1'b0;
    rst = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  initial begin
    rst = 1'b0;
    in_data = '0; in_cnt = '0; in_flush = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_level", 32'(level), 32'd0);
    chk("rst_data", 32'(out_data), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_cnt", byte_cnt, 32'd0);
    rst = 1'b1;

    // Ordering
    rx.delete();
    cycle(16'h00A5, 2'd1, 1'b0, 1'b1);
    cycle(16'h1234, 2'd2, 1'b0, 1'b1);
    repeat (3) cycle(16'h0000, 2'd0, 1'b0, 1'b1);
    chk("order_n", 32'(rx.size()), 32'd3);
    if (rx.size() == 3) begin
      chk("order_0", 32'(rx[0]), 32'hA5);
      chk("order_1", 32'(rx[1]), 32'h12);
      chk("order_2", 32'(rx[2]), 32'h34);
    end

    // Fill and refuse
    apply_reset();
    for (int i = 0; i < 8; i++) cycle(16'(i * 257 + 16'h1020), 2'd2, 1'b0, 1'b0);
    chk("fill_level", 32'(level), 32'd16);
    chk("fill_full", 32'(full), 32'd1);
    chk("fill_ovf", 32'(ovf), 32'd0);
    cycle(16'h0099, 2'd1, 1'b0, 1'b0);
    chk("refuse_ovf", 32'(ovf), 32'd1);
    chk("refuse_level", 32'(level), 32'd16);
    repeat (17) cycle(16'h0000, 2'd0, 1'b0, 1'b1);

    // Simultaneous pop/push at the boundary
    apply_reset();
    for (int i = 0; i < 7; i++) cycle(16'(i + 16'h4000), 2'd2, 1'b0, 1'b0);
    cycle(16'h0055, 2'd1, 1'b0, 1'b0);
    chk("pp_l15", 32'(level), 32'd15);
    cycle(16'hABCD, 2'd2, 1'b0, 1'b1);
    chk("pp_accept_level", 32'(level), 32'd16);
    chk("pp_accept_ovf", 32'(ovf), 32'd0);
    cycle(16'h0000, 2'd0, 1'b0, 1'b1);
    cycle(16'hBEEF, 2'd2, 1'b0, 1'b0);
    chk("pp_refuse_level", 32'(level), 32'd15);
    chk("pp_refuse_ovf", 32'(ovf), 32'd1);
    repeat (16) cycle(16'h0000, 2'd0, 1'b0, 1'b1);

    // Flush tagging
    apply_reset();
    cycle(16'hFF7F, 2'd2, 1'b1, 1'b0);
    chk("fl_first", 32'(out_data), 32'hFF);
    chk("fl_first_last", 32'(out_last), 32'd0);
    cycle(16'h0000, 2'd0, 1'b0, 1'b1);
    chk("fl_second", 32'(out_data), 32'h7F);
    chk("fl_second_last", 32'(out_last), 32'd1);
    cycle(16'h0000, 2'd0, 1'b0, 1'b1);
    cycle(16'h0000, 2'd0, 1'b1, 1'b1);
    chk("fl_empty_last", 32'(out_last), 32'd0);
    chk("fl_empty_ovf", 32'(ovf), 32'd0);
    chk("fl_empty_valid", 32'(out_valid), 32'd0);

    // Wrap: 40 bytes through the ring with toggling ready
    apply_reset();
    rx.delete();
    for (int k = 0; k < 80; k++)
      cycle(16'(k / 2), (k % 2 == 0) ? 2'd1 : 2'd0, 1'b0, (k % 2 == 1));
    repeat (20) cycle(16'h0000, 2'd0, 1'b0, 1'b1);
    chk("wrap_ovf", 32'(ovf), 32'd0);
    chk("wrap_n", 32'(rx.size()), 32'd40);
    for (int i = 0; i < 40 && i < rx.size(); i++) chk("wrap_byte", 32'(rx[i]), 32'(i));
`ifdef BO_BYTE_CNT_EN
    chk("wrap_cnt", byte_cnt, 32'd40);
`endif

    // Random traffic against the model
    apply_reset();
    for (int k = 0; k < 400; k++) begin
      logic [1:0] c;
      c = ($urandom_range(0, 49) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      cycle(16'($urandom), c, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)));
    end

    // Asynchronous reset mid-burst
    apply_reset();
    cycle(16'h0000, 2'd3, 1'b0, 1'b0);
    for (int i = 0; i < 9; i++) cycle(16'(i + 16'h0060), 2'd1, 1'b0, 1'b0);
    chk("mr_level9", 32'(level), 32'd9);
    chk("mr_ovf_set", 32'(ovf), 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("mr_valid", 32'(out_valid), 32'd0);
    chk("mr_level", 32'(level), 32'd0);
    chk("mr_ovf", 32'(ovf), 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b1;
    cycle(16'h005A, 2'd1, 1'b0, 1'b0);
    chk("mr_new_level", 32'(level), 32'd1);
    chk("mr_new_data", 32'(out_data), 32'h5A);
    chk("mr_new_last", 32'(out_last), 32'd0);
    cycle(16'h0000, 2'd0, 1'b0, 1'b1);
    cycle(16'h0000, 2'd0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
